// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - one-hot masks for the four pipeline registers (bit3 IF/ID .. bit0 MEM/WB)
//   - fetch-drop FSM state type
//   - src_hit helper: a source conflicts only when it is actually read,
//     is not x0, and the supplied match condition holds
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [3:0] PIPE_IF_ID  = 4'b1000;
    localparam logic [3:0] PIPE_ID_EX  = 4'b0100;
    localparam logic [3:0] PIPE_EX_MEM = 4'b0010;
    localparam logic [3:0] PIPE_MEM_WB = 4'b0001;
    localparam logic [3:0] PIPE_NONE   = 4'b0000;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DROP = 1'b1
    } fetch_state_t;

    // x0 is hard-wired zero, so it can never be the subject of a hazard
    function automatic logic src_hit(input logic use_src,
                                     input logic rs_nonzero,
                                     input logic cond);
        return use_src & rs_nonzero & cond;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Tracks destinations of in-flight long (mul/div) ops and how many are
// outstanding, and answers whether either ID source depends on one.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_mem_wait                pipe frozen: no new long op is recorded
//   i_ex_long, i_ex_rd        long op issuing from EX and its destination
//   i_id_rs1/2, i_id_use_rs1/2 ID sources and whether they are read
//   i_long_done, i_long_rd    long op writing back and its destination
//   o_sb_hz                   an ID source waits on a long op
//   o_outstanding             number of long ops in flight
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int MAX_LONG = 2,
    localparam int NREG    = 2 ** REG_W,
    localparam int CW      = $clog2(MAX_LONG + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mem_wait,
    input  logic             i_ex_long,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic             i_long_done,
    input  logic [REG_W-1:0] i_long_rd,
    output logic             o_sb_hz,
    output logic [CW-1:0]    o_outstanding
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_LONG);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;
    logic [NREG-1:0] w_busy_eff;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   w_out_next;
    logic            w_set;
    logic            w_clr;

    // Set/clear qualifiers: issue is frozen by mem_wait, completion is not;
    // a completion with nothing outstanding is spurious and ignored.
    always_comb begin
        w_set = (~i_mem_wait) & i_ex_long & (i_ex_rd != {REG_W{1'b0}});
        w_clr = i_long_done & (r_outstanding != {CW{1'b0}});
    end

    // Next busy vector: clear first, then set, so a same-register set wins
    always_comb begin
        w_busy_next = r_busy;
        if (w_clr) begin
            w_busy_next[i_long_rd] = 1'b0;
        end else begin
            w_busy_next = r_busy;
        end
        if (w_set) begin
            w_busy_next[i_ex_rd] = 1'b1;
        end else begin
            w_busy_next[0] = w_busy_next[0];
        end
    end

    // Next outstanding count: simultaneous set and clear cancel out
    always_comb begin
        w_out_next = r_outstanding;
        case ({w_set, w_clr})
            2'b10: begin
                if (r_outstanding != MAX_C) begin
                    w_out_next = r_outstanding + CW'(1);
                end else begin
                    w_out_next = r_outstanding;
                end
            end
            2'b01:   w_out_next = r_outstanding - CW'(1);
            default: w_out_next = r_outstanding;
        endcase
    end

    // Scoreboard state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy        <= {NREG{1'b0}};
            r_outstanding <= {CW{1'b0}};
        end else begin
            r_busy        <= w_busy_next;
            r_outstanding <= w_out_next;
        end
    end

    // Source lookups; while in reset the state is treated as already cleared.
    // A long op issuing this cycle is caught via ex_rd before busy is set.
    always_comb begin
        w_busy_eff    = i_rst ? {NREG{1'b0}} : r_busy;
        o_outstanding = i_rst ? {CW{1'b0}} : r_outstanding;
        o_sb_hz =
            src_hit(i_id_use_rs1, i_id_rs1 != {REG_W{1'b0}},
                    w_busy_eff[i_id_rs1] | (i_ex_long & (i_id_rs1 == i_ex_rd))) |
            src_hit(i_id_use_rs2, i_id_rs2 != {REG_W{1'b0}},
                    w_busy_eff[i_id_rs2] | (i_ex_long & (i_id_rs2 == i_ex_rd)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the 5-stage core. Combines load-use,
// long-op scoreboard and long-op capacity hazards with the data-memory
// freeze and jump flush, squashes a fetch response that was in flight
// when a jump resolved, and counts PC-stall cycles (saturating).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_wait, if_valid           fetch outstanding / fetch response present
//   mem_wait                    data memory busy, whole pipe holds
//   ex_jump, ex_load, ex_long   EX instruction class, ex_rd its destination
//   id_rs1/2, id_use_rs1/2      ID sources and whether they are read
//   id_long                     ID holds a long op
//   long_done, long_rd          long op write-back
//   pc_pause, pipe_pause[3:0], pipe_bubble[3:0]  pipeline controls
//   drop_fetch                  discard the current fetch response
//   stall_cnt                   saturating count of pc_pause cycles
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int MAX_LONG = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_wait,
    input  logic             if_valid,
    input  logic             mem_wait,
    input  logic             ex_jump,
    input  logic             ex_load,
    input  logic             ex_long,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_long,
    input  logic             long_done,
    input  logic [REG_W-1:0] long_rd,
    output logic             pc_pause,
    output logic [3:0]       pipe_pause,
    output logic [3:0]       pipe_bubble,
    output logic             drop_fetch,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int CW = $clog2(MAX_LONG + 1);
    localparam logic [CW-1:0]    MAX_C   = CW'(MAX_LONG);
    localparam logic [CW-1:0]    MAX_M1  = CW'(MAX_LONG - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CW-1:0]    w_outstanding;
    logic             w_sb_hz;
    logic             w_load_hz;
    logic             w_full_hz;
    logic             w_any_hz;
    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    fetch_state_t     w_state_eff;
    logic [CNT_W-1:0] r_stall_cnt;

    hazard_scoreboard #(
        .REG_W    (REG_W),
        .MAX_LONG (MAX_LONG)
    ) u_scoreboard (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_mem_wait    (mem_wait),
        .i_ex_long     (ex_long),
        .i_ex_rd       (ex_rd),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_use_rs1  (id_use_rs1),
        .i_id_use_rs2  (id_use_rs2),
        .i_long_done   (long_done),
        .i_long_rd     (long_rd),
        .o_sb_hz       (w_sb_hz),
        .o_outstanding (w_outstanding)
    );

    // Hazard detection: load-use, and long-op capacity (the EX long op
    // issuing this cycle already occupies a slot)
    always_comb begin
        w_load_hz = ex_load & (
            src_hit(id_use_rs1, id_rs1 != {REG_W{1'b0}}, id_rs1 == ex_rd) |
            src_hit(id_use_rs2, id_rs2 != {REG_W{1'b0}}, id_rs2 == ex_rd));
        w_full_hz = id_long & ((w_outstanding == MAX_C) |
                               ((w_outstanding == MAX_M1) & ex_long));
        w_any_hz  = w_load_hz | w_sb_hz | w_full_hz;
    end

    // Fetch FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fetch FSM next state: a jump with a fetch still in flight means the
    // response that eventually arrives belongs to the wrong path
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (ex_jump && if_wait && !if_valid && !mem_wait) begin
                    w_state_next = DROP;
                end else begin
                    w_state_next = RUN;
                end
            end
            DROP: begin
                if (if_valid) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = DROP;
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    // Control outputs in priority order; in reset the FSM reads as RUN
    always_comb begin
        w_state_eff = rst ? RUN : r_state;
        pc_pause    = 1'b0;
        pipe_pause  = PIPE_NONE;
        pipe_bubble = PIPE_NONE;
        if (mem_wait) begin
            pc_pause   = 1'b1;
            pipe_pause = PIPE_IF_ID | PIPE_ID_EX | PIPE_EX_MEM | PIPE_MEM_WB;
        end else if (ex_jump) begin
            pipe_bubble = PIPE_IF_ID | PIPE_ID_EX;
        end else if (w_any_hz) begin
            pc_pause    = 1'b1;
            pipe_pause  = PIPE_IF_ID;
            pipe_bubble = PIPE_ID_EX;
        end else if (if_wait || (w_state_eff == DROP)) begin
            pipe_bubble = PIPE_IF_ID;
        end else begin
            pipe_bubble = PIPE_NONE;
        end
        drop_fetch = (w_state_eff == DROP) & if_valid;
        stall_cnt  = rst ? {CNT_W{1'b0}} : r_stall_cnt;
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (pc_pause && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Scoreboard bench: each applied input vector gets its expected outputs from
// a rule-level reference model pushed into a queue; a monitor on the falling
// edge pops and compares. Directed scenarios first, then random traffic.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int REG_W    = 5;
    localparam int MAX_LONG = 2;
    localparam int CNT_W    = 3;
    localparam int NREG     = 2 ** REG_W;
    localparam int CNT_TOP  = (2 ** CNT_W) - 1;

    typedef struct packed {
        logic       rst;
        logic       if_wait;
        logic       if_valid;
        logic       mem_wait;
        logic       ex_jump;
        logic       ex_load;
        logic       ex_long;
        logic [4:0] ex_rd;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_use_rs1;
        logic       id_use_rs2;
        logic       id_long;
        logic       long_done;
        logic [4:0] long_rd;
    } stim_t;

    typedef struct packed {
        logic       pc;
        logic [3:0] pause;
        logic [3:0] bubble;
        logic       drop;
        logic [2:0] cnt;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic if_wait = 1'b0, if_valid = 1'b0, mem_wait = 1'b0, ex_jump = 1'b0;
    logic ex_load = 1'b0, ex_long = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic id_long = 1'b0, long_done = 1'b0;
    logic [REG_W-1:0] ex_rd = '0, id_rs1 = '0, id_rs2 = '0, long_rd = '0;
    logic             pc_pause, drop_fetch;
    logic [3:0]       pipe_pause, pipe_bubble;
    logic [CNT_W-1:0] stall_cnt;

    // reference model state
    bit m_busy [NREG];
    int m_outs;
    bit m_drop;
    int m_cnt;

    resp_t exp_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(REG_W), .MAX_LONG(MAX_LONG), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .if_wait(if_wait), .if_valid(if_valid),
        .mem_wait(mem_wait), .ex_jump(ex_jump), .ex_load(ex_load),
        .ex_long(ex_long), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_long(id_long),
        .long_done(long_done), .long_rd(long_rd), .pc_pause(pc_pause),
        .pipe_pause(pipe_pause), .pipe_bubble(pipe_bubble),
        .drop_fetch(drop_fetch), .stall_cnt(stall_cnt)
    );

    function automatic bit conflicts(input bit use_src, input logic [4:0] rs, input bit cond);
        return use_src && (rs != 5'd0) && cond;
    endfunction

    // Drive one vector, predict outputs from the rules, then advance the model
    task automatic apply(input stim_t s);
        resp_t e;
        bit    load_hz, sb_hz, full_hz, set_b, clr_b;
        bit    b1, b2, drop_e;
        int    outs_e;
        @(posedge clk);
        #1;
        rst = s.rst; if_wait = s.if_wait; if_valid = s.if_valid;
        mem_wait = s.mem_wait; ex_jump = s.ex_jump; ex_load = s.ex_load;
        ex_long = s.ex_long; ex_rd = s.ex_rd; id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
        id_use_rs1 = s.id_use_rs1; id_use_rs2 = s.id_use_rs2; id_long = s.id_long;
        long_done = s.long_done; long_rd = s.long_rd;

        // in reset every piece of state reads as cleared
        b1     = !s.rst && m_busy[s.id_rs1];
        b2     = !s.rst && m_busy[s.id_rs2];
        outs_e = s.rst ? 0 : m_outs;
        drop_e = !s.rst && m_drop;

        load_hz = s.ex_load && (conflicts(s.id_use_rs1, s.id_rs1, s.id_rs1 == s.ex_rd) ||
                                conflicts(s.id_use_rs2, s.id_rs2, s.id_rs2 == s.ex_rd));
        sb_hz   = conflicts(s.id_use_rs1, s.id_rs1, b1 || (s.ex_long && s.id_rs1 == s.ex_rd)) ||
                  conflicts(s.id_use_rs2, s.id_rs2, b2 || (s.ex_long && s.id_rs2 == s.ex_rd));
        full_hz = s.id_long && ((outs_e == MAX_LONG) || (outs_e == MAX_LONG - 1 && s.ex_long));

        e = '0;
        if (s.mem_wait) begin
            e.pc = 1'b1; e.pause = 4'b1111;
        end else if (s.ex_jump) begin
            e.bubble = 4'b1100;
        end else if (load_hz || sb_hz || full_hz) begin
            e.pc = 1'b1; e.pause = 4'b1000; e.bubble = 4'b0100;
        end else if (s.if_wait || drop_e) begin
            e.bubble = 4'b1000;
        end
        e.drop = drop_e && s.if_valid;
        e.cnt  = s.rst ? 3'd0 : 3'(m_cnt);
        exp_q.push_back(e);

        if (s.rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_outs = 0; m_drop = 1'b0; m_cnt = 0;
        end else begin
            set_b = !s.mem_wait && s.ex_long && (s.ex_rd != 5'd0);
            clr_b = s.long_done && (m_outs > 0);
            if (clr_b) m_busy[s.long_rd] = 1'b0;
            if (set_b) m_busy[s.ex_rd] = 1'b1;
            m_outs = m_outs + int'(set_b) - int'(clr_b);
            if (m_drop) begin
                if (s.if_valid) m_drop = 1'b0;
            end else if (s.ex_jump && s.if_wait && !s.if_valid && !s.mem_wait) begin
                m_drop = 1'b1;
            end
            if (e.pc && m_cnt < CNT_TOP) m_cnt++;
        end
    endtask

    // Monitor: one response per cycle, compared on the falling edge
    always @(negedge clk) begin
        resp_t e;
        resp_t g;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = {pc_pause, pipe_pause, pipe_bubble, drop_fetch, stall_cnt};
            n_vec++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL outputs vec %0d: got pc=%b pause=%b bubble=%b drop=%b cnt=%0d, want pc=%b pause=%b bubble=%b drop=%b cnt=%0d",
                         n_vec, g.pc, g.pause, g.bubble, g.drop, g.cnt,
                         e.pc, e.pause, e.bubble, e.drop, e.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        int    pick;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_outs = 0; m_drop = 1'b0; m_cnt = 0;

        s = '0; s.rst = 1'b1; apply(s); apply(s);

        // load-use on rs2, then same with ex_rd = x0
        s = '0; s.ex_load = 1'b1; s.ex_rd = 5'd5; s.id_rs2 = 5'd5; s.id_use_rs2 = 1'b1;
        apply(s); apply(s);
        s.ex_rd = 5'd0; s.id_rs2 = 5'd0; apply(s);

        // long op to x7 with a dependent in ID until completion
        s = '0; s.ex_long = 1'b1; s.ex_rd = 5'd7; s.id_rs1 = 5'd7; s.id_use_rs1 = 1'b1;
        apply(s);
        s.ex_long = 1'b0; s.ex_rd = 5'd0; apply(s); apply(s);
        s.long_done = 1'b1; s.long_rd = 5'd7; apply(s);
        s.long_done = 1'b0; apply(s);

        // completion and reissue of x7 in the same cycle
        s = '0; s.ex_long = 1'b1; s.ex_rd = 5'd7; apply(s);
        s.long_done = 1'b1; s.long_rd = 5'd7; apply(s);
        s = '0; s.id_rs1 = 5'd7; s.id_use_rs1 = 1'b1; apply(s);
        s.long_done = 1'b1; s.long_rd = 5'd7; apply(s);
        s.long_done = 1'b0; apply(s);

        // capacity: two long ops in flight block a third
        s = '0; s.ex_long = 1'b1; s.ex_rd = 5'd3; apply(s);
        s.ex_rd = 5'd4; apply(s);
        s = '0; s.id_long = 1'b1; apply(s);
        s.long_done = 1'b1; s.long_rd = 5'd3; apply(s);
        s.long_done = 1'b0; apply(s);
        s = '0; s.long_done = 1'b1; s.long_rd = 5'd4; apply(s);

        // jump while a fetch is outstanding, late response dropped
        s = '0; s.if_wait = 1'b1; s.ex_jump = 1'b1; apply(s);
        s.ex_jump = 1'b0; apply(s); apply(s);
        s.if_wait = 1'b0; s.if_valid = 1'b1; apply(s);
        s.if_valid = 1'b0; apply(s);

        // mem_wait overrides jump and load-use, then release
        s = '0; s.mem_wait = 1'b1; s.ex_jump = 1'b1; s.if_wait = 1'b1;
        s.ex_load = 1'b1; s.ex_rd = 5'd2; s.id_rs1 = 5'd2; s.id_use_rs1 = 1'b1;
        apply(s); apply(s);
        s.mem_wait = 1'b0; apply(s);
        s = '0; s.if_valid = 1'b1; apply(s);

        // stall counter saturation
        s = '0; s.ex_load = 1'b1; s.ex_rd = 5'd9; s.id_rs1 = 5'd9; s.id_use_rs1 = 1'b1;
        repeat (10) apply(s);

        // reset while in DROP; the next response must not be dropped
        s = '0; s.if_wait = 1'b1; s.ex_jump = 1'b1; apply(s);
        s = '0; s.rst = 1'b1; s.if_valid = 1'b1; apply(s);
        s.rst = 1'b0; apply(s);
        s.if_valid = 1'b0; apply(s);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            s = '0;
            s.rst      = ($urandom_range(0, 99) == 0);
            s.if_valid = ($urandom_range(0, 3) == 0);
            s.if_wait  = s.if_valid ? 1'b0 : 1'($urandom_range(0, 1));
            s.mem_wait = ($urandom_range(0, 7) == 0);
            s.ex_jump  = ($urandom_range(0, 7) == 0);
            pick = $urandom_range(0, 3);
            s.ex_rd = 5'($urandom_range(0, 7));
            if (pick == 0) begin
                s.ex_load = 1'b1;
            end else if (pick == 1 && m_outs < MAX_LONG) begin
                s.ex_long = 1'b1;
                s.ex_rd   = 5'($urandom_range(1, 7));
            end
            s.id_rs1     = 5'($urandom_range(0, 7));
            s.id_rs2     = 5'($urandom_range(0, 7));
            s.id_use_rs1 = 1'($urandom_range(0, 1));
            s.id_use_rs2 = 1'($urandom_range(0, 1));
            s.id_long    = ($urandom_range(0, 3) == 0);
            if (m_outs > 0 && $urandom_range(0, 2) == 0) begin
                s.long_done = 1'b1;
                s.long_rd   = 5'($urandom_range(1, 7));
                for (int r = 1; r < 8; r++) begin
                    if (m_busy[r] && $urandom_range(0, 1) == 1) s.long_rd = 5'(r);
                end
            end
            apply(s);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d responses never checked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
